// File: rtl/max_pool_reduce.sv
// ---------------------------------------------------------------------------
// max_pool_reduce
// Single-lane 2x2 max-pool reduction stage. Collects the four operands of a
// pooling window (tagged by a one-hot slot select), reduces them through a
// two-stage registered signed compare tree and queues each result with its
// output address in a 2-entry FIFO drained by a valid/ready handshake.
//
// Optional feature: define MAXPOOL_RELU_EN to clamp negative results to 0
// (fused ReLU). Without it the signed maximum passes through unchanged.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   data_in     window element read data (signed)
//   sel         one-hot slot of data_in: bit0 TL, bit1 TR, bit2 BL, bit3 BR
//   data_valid  data_in/sel valid this cycle
//   done_in     fill lane finished; flush any partial window
//   out_data    pooled result at FIFO head
//   out_add     output address of out_data
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head this cycle
//   frame_done  one-cycle pulse when the last address of a frame is pushed
//   err         sticky errors: [0] bad sel, [1] partial flush, [2] overflow
// ---------------------------------------------------------------------------
module max_pool_reduce #(
   parameter int data_size   = 16,
   parameter int matrix_size = 16,
   parameter int add_size    = 14
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [data_size-1:0] data_in,
   input  logic [3:0]                  sel,
   input  logic                        data_valid,
   input  logic                        done_in,
   output logic signed [data_size-1:0] out_data,
   output logic [add_size-1:0]         out_add,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        frame_done,
   output logic [2:0]                  err
);

   localparam int unsigned HALF     = matrix_size / 2;
   localparam int unsigned LAST_INT = HALF * HALF - 1;
   localparam logic [add_size-1:0] LAST_ADDR = LAST_INT[add_size-1:0];
   localparam logic [add_size-1:0] ADDR_ONE  = {{(add_size-1){1'b0}}, 1'b1};

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   function automatic logic signed [data_size-1:0] smax(
      input logic signed [data_size-1:0] a,
      input logic signed [data_size-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // window capture state
   logic signed [data_size-1:0] w_q [4];
   logic signed [data_size-1:0] w_d [4];
   logic [3:0]                  mask_q, mask_d;
   logic                        complete_s, flush_s, bad_sel_s;

   // compare pipeline
   logic                        v1_q, v2_q;
   logic signed [data_size-1:0] m01_q, m23_q;
   logic signed [data_size-1:0] res_s;

   // result FIFO and address counter
   logic signed [data_size-1:0] fifo_data_q [2];
   logic [add_size-1:0]         fifo_add_q  [2];
   logic                        wr_ptr_q, rd_ptr_q;
   logic [1:0]                  count_q, count_d;
   logic                        pop_s, push_s, drop_s, wr_en_s;
   logic [add_size-1:0]         addr_q, addr_d;
   logic                        frame_done_q, frame_done_d;
   logic [2:0]                  err_q, err_d;

   // Window capture, completion and flush; the flush is judged on the mask
   // left after this cycle's capture (a completed window already cleared it).
   always_comb begin
      w_d        = w_q;
      mask_d     = mask_q;
      complete_s = 1'b0;
      flush_s    = 1'b0;
      bad_sel_s  = 1'b0;
      if (data_valid) begin
         if (is_onehot4(sel)) begin
            for (int i = 0; i < 4; i++) begin
               w_d[i] = sel[i] ? data_in : w_q[i];
            end
            mask_d = mask_q | sel;
         end else begin
            bad_sel_s = 1'b1;
         end
      end else begin
         bad_sel_s = 1'b0;
      end
      if (mask_d == 4'b1111) begin
         complete_s = 1'b1;
         mask_d     = 4'b0000;
      end else begin
         complete_s = 1'b0;
      end
      if (done_in && (mask_d != 4'b0000)) begin
         flush_s = 1'b1;
         mask_d  = 4'b0000;
      end else begin
         flush_s = 1'b0;
      end
   end

   // Stage-2 reduction with optional ReLU clamp
   always_comb begin
      res_s = smax(m01_q, m23_q);
`ifdef MAXPOOL_RELU_EN
      if (res_s[data_size-1]) begin
         res_s = '0;
      end else begin
         res_s = smax(m01_q, m23_q);
      end
`endif
   end

   // FIFO control, address counter and sticky error next state
   always_comb begin
      pop_s        = (count_q != 2'd0) && out_ready;
      push_s       = v2_q;
      // push into a full FIFO is only legal when the head leaves this cycle
      drop_s       = push_s && (count_q == 2'd2) && !pop_s;
      wr_en_s      = push_s && !drop_s;
      addr_d       = addr_q;
      frame_done_d = 1'b0;
      if (push_s) begin
         if (addr_q == LAST_ADDR) begin
            addr_d       = '0;
            frame_done_d = 1'b1;
         end else begin
            addr_d       = addr_q + ADDR_ONE;
            frame_done_d = 1'b0;
         end
      end else begin
         addr_d = addr_q;
      end
      case ({wr_en_s, pop_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      err_d = err_q | {drop_s, flush_s, bad_sel_s};
   end

   // All state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            w_q[i] <= '0;
         end
         for (int j = 0; j < 2; j++) begin
            fifo_data_q[j] <= '0;
            fifo_add_q[j]  <= '0;
         end
         mask_q       <= 4'b0000;
         v1_q         <= 1'b0;
         v2_q         <= 1'b0;
         m01_q        <= '0;
         m23_q        <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         addr_q       <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 3'b000;
      end else begin
         w_q    <= w_d;
         mask_q <= mask_d;
         // w_q still holds the complete window for one cycle after it fills
         v1_q   <= complete_s;
         if (v1_q) begin
            m01_q <= smax(w_q[0], w_q[1]);
            m23_q <= smax(w_q[2], w_q[3]);
         end
         v2_q <= v1_q;
         if (wr_en_s) begin
            fifo_data_q[wr_ptr_q] <= res_s;
            fifo_add_q[wr_ptr_q]  <= addr_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q      <= count_d;
         addr_q       <= addr_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign out_data   = fifo_data_q[rd_ptr_q];
   assign out_add    = fifo_add_q[rd_ptr_q];
   assign out_valid  = (count_q != 2'd0);
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_max_pool_reduce.sv
// ---------------------------------------------------------------------------
// tb_max_pool_reduce
// Directed self-checking bench for max_pool_reduce (matrix_size = 4, so a
// frame is four output addresses). Build with +define+MAXPOOL_RELU_EN to
// check the fused-ReLU variant.
// ---------------------------------------------------------------------------
module tb_max_pool_reduce;

   localparam int DS = 16;
   localparam int MS = 4;
   localparam int AS = 14;

   logic                 clk;
   logic                 reset;
   logic signed [DS-1:0] data_in;
   logic [3:0]           sel;
   logic                 data_valid;
   logic                 done_in;
   logic signed [DS-1:0] out_data;
   logic [AS-1:0]        out_add;
   logic                 out_valid;
   logic                 out_ready;
   logic                 frame_done;
   logic [2:0]           err;

   int checks_cnt;
   int errors_cnt;
   int q_data [$];
   int q_add  [$];
   int q_fd   [$];
   int fd_cnt;

   max_pool_reduce #(.data_size(DS), .matrix_size(MS), .add_size(AS)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .sel        (sel),
      .data_valid (data_valid),
      .done_in    (done_in),
      .out_data   (out_data),
      .out_add    (out_add),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record every accepted result away from the active edge
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         q_data.push_back(int'(out_data));
         q_add.push_back(int'(out_add));
         q_fd.push_back(int'(frame_done));
      end
      if (reset && frame_done) fd_cnt++;
   end

   task automatic check_eq(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int qget(input int which, input int idx);
      if (which == 0) return (idx < q_data.size()) ? q_data[idx] : -99999;
      if (which == 1) return (idx < q_add.size())  ? q_add[idx]  : -99999;
      return (idx < q_fd.size()) ? q_fd[idx] : -99999;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      data_valid = 1'b0;
      done_in    = 1'b0;
      sel        = 4'b0000;
      data_in    = '0;
      out_ready  = 1'b1;
      step(2);
      reset = 1'b1;
      q_data.delete();
      q_add.delete();
      q_fd.delete();
      fd_cnt = 0;
   endtask

   task automatic send_elem(input logic [3:0] s, input int d);
      data_valid = 1'b1;
      sel        = s;
      data_in    = DS'(d);
      step(1);
      data_valid = 1'b0;
      sel        = 4'b0000;
   endtask

   task automatic send_window(input int a, input int b, input int c, input int d);
      send_elem(4'b0001, a);
      send_elem(4'b0010, b);
      send_elem(4'b0100, c);
      send_elem(4'b1000, d);
   endtask

   initial begin
      int exp_neg;
      checks_cnt = 0;
      errors_cnt = 0;
`ifdef MAXPOOL_RELU_EN
      exp_neg = 0;
`else
      exp_neg = -2;
`endif
      // ---- reset state
      reset = 1'b0; data_valid = 1'b0; done_in = 1'b0; sel = 4'b0000;
      data_in = '0; out_ready = 1'b1; fd_cnt = 0;
      step(2);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_add", out_add, 0);
      check_eq("rst_fd", frame_done, 0);
      check_eq("rst_err", err, 0);
      do_reset();

      // ---- basic window and latency
      send_window(3, -7, 12, 5);
      check_eq("lat_n0", out_valid, 0);
      step(1);
      check_eq("lat_n1", out_valid, 0);
      step(1);
      check_eq("lat_n2", out_valid, 1);
      check_eq("w1_data", out_data, 12);
      check_eq("w1_add", out_add, 0);
      step(1);
      check_eq("w1_popped", out_valid, 0);

      // ---- all-negative window
      send_window(-4, -9, -2, -30);
      step(2);
      check_eq("neg_valid", out_valid, 1);
      check_eq("neg_data", out_data, exp_neg);
      check_eq("neg_add", out_add, 1);
      step(2);

      // ---- address wrap and frame_done over back-to-back windows
      do_reset();
      send_window(1, 2, 3, 4);
      send_window(10, -1, 0, 0);
      send_window(-5, 7, -6, 6);
      send_window(0, 0, 0, 99);
      send_window(50, -50, 60, -60);
      step(6);
      check_eq("wrap_cnt", q_data.size(), 5);
      check_eq("wrap_d0", qget(0, 0), 4);
      check_eq("wrap_d1", qget(0, 1), 10);
      check_eq("wrap_d2", qget(0, 2), 7);
      check_eq("wrap_d3", qget(0, 3), 99);
      check_eq("wrap_d4", qget(0, 4), 60);
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("wrap_a%0d", i), qget(1, i), (i == 4) ? 0 : i);
         check_eq($sformatf("wrap_fd%0d", i), qget(2, i), (i == 3) ? 1 : 0);
      end
      check_eq("wrap_fd_pulses", fd_cnt, 1);
      check_eq("wrap_err", err, 0);

      // ---- backpressure: two held, third dropped
      do_reset();
      out_ready = 1'b0;
      send_window(5, 1, 2, 3);
      send_window(-1, 8, -3, 2);
      send_window(9, 9, 9, 9);
      step(4);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_head_data", out_data, 5);
      check_eq("bp_head_add", out_add, 0);
      check_eq("bp_err", err, 3'b100);
      out_ready = 1'b1;
      step(4);
      check_eq("bp_drain_cnt", q_data.size(), 2);
      check_eq("bp_d0", qget(0, 0), 5);
      check_eq("bp_a0", qget(1, 0), 0);
      check_eq("bp_d1", qget(0, 1), 8);
      check_eq("bp_a1", qget(1, 1), 1);
      check_eq("bp_empty", out_valid, 0);
      send_window(2, 2, 2, 2);
      step(4);
      check_eq("bp_next_d", qget(0, 2), 2);
      check_eq("bp_next_a", qget(1, 2), 3);
      check_eq("bp_next_fd", qget(2, 2), 1);

      // ---- bad select leaves the mask alone
      do_reset();
      send_elem(4'b0001, 1);
      send_elem(4'b0011, 77);
      check_eq("bad_sel_err", err, 3'b001);
      send_elem(4'b0010, 1);
      send_elem(4'b0100, 1);
      send_elem(4'b1000, 1);
      step(4);
      check_eq("bad_sel_cnt", q_data.size(), 1);
      check_eq("bad_sel_data", qget(0, 0), 1);

      // ---- partial flush on done_in
      do_reset();
      send_elem(4'b0001, 50);
      send_elem(4'b0010, 60);
      done_in = 1'b1;
      step(1);
      done_in = 1'b0;
      step(3);
      check_eq("flush_no_out", q_data.size(), 0);
      check_eq("flush_err", err, 3'b010);
      send_elem(4'b0100, 3);
      send_elem(4'b1000, 2);
      send_elem(4'b0001, 6);
      send_elem(4'b0010, -1);
      step(4);
      check_eq("flush_cnt", q_data.size(), 1);
      check_eq("flush_data", qget(0, 0), 6);
      check_eq("flush_add", qget(1, 0), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
